rr_mux4_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 selection datapath between four requesters.
- Each requester owns one data input: a, b, c or d.
- The block grants one requester at a time and drives the 2-bit select.
- It presents the granted requester's data on y with a valid flag.
- A configurable hold limit stops any requester from monopolising the shared output.

---
 rtl/rr_mux4_arbiter_if.sv | 12 +
 rtl/rr_mux4_arbiter.sv | 110 +++++++++++
 tb/tb_rr_mux4_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rr_mux4_arbiter_if.sv
// Request/grant bundle between four requesters and the shared round-robin 4:1 selector.
interface rr_mux4_arbiter_if #(parameter int DW = 1);
   logic [3:0]    req;
   logic [DW-1:0] a, b, c, d;
   logic [3:0]    gnt;
   logic [1:0]    sel;
   logic [DW-1:0] y;
   logic          vld;

   modport master (output req, a, b, c, d, input gnt, sel, y, vld);
   modport slave  (input req, a, b, c, d, output gnt, sel, y, vld);
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter with a per-grant hold limit, driving a shared 4:1 data mux.
module rr_mux4_arbiter #(
   parameter int DW       = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   rr_mux4_arbiter_if.slave  bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_HOLD);

   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] cnt_q, cnt_d;

   logic [3:0] others;
   logic [1:0] owner;
   logic [1:0] win;

   // First set bit of r in the order start, start+1, start+2, start+3 (mod 4).
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
      logic [1:0] idx;
      pick = start;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (r[idx]) pick = idx;
      end
   endfunction

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      owner   = sel_q;
      others  = bus.req & ~(4'b0001 << owner);
      win     = '0;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               win     = pick(bus.req, ptr_q);
               gnt_d   = 4'b0001 << win;
               sel_d   = win;
               cnt_d   = 4'd1;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (bus.req[owner] && cnt_q < MAX_CNT) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               ptr_d = owner + 2'd1;
               if (|others) begin
                  win   = pick(others, owner + 2'd1);
                  gnt_d = 4'b0001 << win;
                  sel_d = win;
                  cnt_d = 4'd1;
               end else if (bus.req[owner]) begin
                  // Sole requester at its hold limit: restart its hold window.
                  cnt_d = 4'd1;
               end else begin
                  gnt_d   = 4'b0000;
                  cnt_d   = 4'd0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   logic [DW-1:0] y_mux;

   always_comb begin
      case (sel_q)
         2'd0:    y_mux = bus.a;
         2'd1:    y_mux = bus.b;
         2'd2:    y_mux = bus.c;
         default: y_mux = bus.d;
      endcase
   end

   assign bus.gnt = gnt_q;
   assign bus.sel = sel_q;
   assign bus.vld = |gnt_q;
   assign bus.y   = bus.vld ? y_mux : '0;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: hand-computed grant sequences checked with immediate assertions.
module tb_rr_mux4_arbiter;
   localparam int DW = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   rr_mux4_arbiter_if #(.DW(DW)) bus ();

   rr_mux4_arbiter #(.DW(DW), .MAX_HOLD(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req = 4'b0000;
      rst_n   = 1'b0;
      #1;
      rst_n   = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.req = 4'b0000;
      bus.a = 4'h1; bus.b = 4'h2; bus.c = 4'h3; bus.d = 4'h4;
      #2;
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_sel", 32'(bus.sel), 32'h0);
      chk("rst_vld", 32'(bus.vld), 32'h0);
      chk("rst_y",   32'(bus.y),   32'h0);
      rst_n = 1'b1;

      // Single requester c, held three cycles then dropped.
      bus.req = 4'b0100;
      tick();
      chk("c_gnt", 32'(bus.gnt), 32'h4);
      chk("c_sel", 32'(bus.sel), 32'h2);
      chk("c_vld", 32'(bus.vld), 32'h1);
      chk("c_y",   32'(bus.y),   32'h3);
      bus.c = 4'h9;
      #1;
      chk("c_y_comb", 32'(bus.y), 32'h9);
      bus.c = 4'h6;
      #1;
      chk("c_y_comb2", 32'(bus.y), 32'h6);
      tick();
      tick();
      chk("c_hold_gnt", 32'(bus.gnt), 32'h4);
      bus.req = 4'b0000;
      tick();
      chk("c_drop_gnt", 32'(bus.gnt), 32'h0);
      chk("c_drop_vld", 32'(bus.vld), 32'h0);
      chk("c_drop_y",   32'(bus.y),   32'h0);
      chk("c_drop_sel", 32'(bus.sel), 32'h2);

      // All four requesting: four cycles each, a -> b -> c -> d -> a.
      do_reset();
      bus.req = 4'b1111;
      for (int k = 0; k < 17; k++) begin
         tick();
         chk("all_gnt", 32'(bus.gnt), 32'(4'b0001 << ((k / 4) % 4)));
         chk("all_vld", 32'(bus.vld), 32'h1);
      end

      // Sole requester b past the hold limit: continuous grant, counter restarts.
      do_reset();
      bus.req = 4'b0010;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("solo_gnt", 32'(bus.gnt), 32'h2);
         chk("solo_sel", 32'(bus.sel), 32'h1);
         chk("solo_cnt", 32'(dut.cnt_q), 32'((k % 4) + 1));
      end

      // Wrap-around: owner d releases with a and b pending, a must win.
      do_reset();
      bus.req = 4'b1000;
      tick();
      chk("wrap_own_d", 32'(bus.gnt), 32'h8);
      bus.req = 4'b0011;
      tick();
      chk("wrap_gnt", 32'(bus.gnt), 32'h1);
      chk("wrap_sel", 32'(bus.sel), 32'h0);
      chk("wrap_y",   32'(bus.y),   32'h1);

      // Asynchronous reset between edges while b owns the grant.
      do_reset();
      bus.req = 4'b0010;
      tick();
      chk("arst_pre", 32'(bus.gnt), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_gnt", 32'(bus.gnt), 32'h0);
      chk("arst_vld", 32'(bus.vld), 32'h0);
      chk("arst_y",   32'(bus.y),   32'h0);
      chk("arst_sel", 32'(bus.sel), 32'h0);
      bus.req = 4'b1111;
      rst_n = 1'b1;
      tick();
      chk("arst_first", 32'(bus.gnt), 32'h1);

      // Release by b in the same cycle c arrives: no idle cycle in between.
      do_reset();
      bus.req = 4'b0010;
      tick();
      chk("simul_pre", 32'(bus.gnt), 32'h2);
      bus.req = 4'b0100;
      tick();
      chk("simul_gnt", 32'(bus.gnt), 32'h4);
      chk("simul_vld", 32'(bus.vld), 32'h1);
      chk("simul_sel", 32'(bus.sel), 32'h2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
